// File: rtl/ctrl_pkg.sv
// ctrl_pkg: FSM states, instruction class/opcode/condition codes and mux-select codes for control_unit.
package ctrl_pkg;
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {CLS_RALU, CLS_IALU, CLS_MEMSHR, CLS_CTRL} cls_t;
    typedef enum logic [1:0] {BR_Z, BR_NZ, BR_C, BR_NC} br_cond_t;
    typedef enum logic [1:0] {JG_JMP, JG_JSB, JG_RET, JG_ILL} jg_op_t;
    typedef enum logic [2:0] {ALU_ADD, ALU_ADDC, ALU_SUB, ALU_SUBC, ALU_AND, ALU_OR, ALU_XOR, ALU_MASK} alu_op_t;
    typedef enum logic [1:0] {PC_SRC_INC, PC_SRC_BR, PC_SRC_JMP, PC_SRC_STK} pc_src_t;
    typedef enum logic [1:0] {WD_SRC_ALU, WD_SRC_MEM, WD_SRC_SHR} wd_src_t;

    function automatic logic br_taken(input logic [1:0] cond, input logic z, input logic c);
        return cond == BR_Z ? z : cond == BR_NZ ? !z : cond == BR_C ? c : !c;
    endfunction
endpackage

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: combinational IR decode into instruction-class strobes and opcode fields.
//   ir            : latched instruction register
//   is_alu/is_imm : R- or I-type ALU / I-type only
//   is_ldm/is_stm/is_shift/is_branch/is_jmp/is_jsb/is_ret/is_bad : class strobes
//   alu_op        : IR[16:14]; sub_op : IR[15:14] (shift op, branch condition or jump-group op)
module ctrl_decoder
    import ctrl_pkg::*;
(
    input  logic [18:0] ir,
    output logic        is_alu,
    output logic        is_imm,
    output logic        is_ldm,
    output logic        is_stm,
    output logic        is_shift,
    output logic        is_branch,
    output logic        is_jmp,
    output logic        is_jsb,
    output logic        is_ret,
    output logic        is_bad,
    output logic [2:0]  alu_op,
    output logic [1:0]  sub_op
);
    logic mem_shr, ctrl, jump;
    // Operand fields feed the datapath straight from instruction memory, not the controller.
    logic unused_operands;

    assign mem_shr   = ir[18:17] == CLS_MEMSHR;
    assign ctrl      = ir[18:17] == CLS_CTRL;
    assign jump      = ctrl && ir[16];
    assign alu_op    = ir[16:14];
    assign sub_op    = ir[15:14];
    assign is_alu    = ir[18:17] == CLS_RALU || ir[18:17] == CLS_IALU;
    assign is_imm    = ir[18:17] == CLS_IALU;
    assign is_ldm    = mem_shr && !ir[16] && !ir[15];
    assign is_stm    = mem_shr && !ir[16] && ir[15];
    assign is_shift  = mem_shr && ir[16];
    assign is_branch = ctrl && !ir[16];
    assign is_jmp    = jump && sub_op == JG_JMP;
    assign is_jsb    = jump && sub_op == JG_JSB;
    assign is_ret    = jump && sub_op == JG_RET;
    assign is_bad    = jump && sub_op == JG_ILL;
    assign unused_operands = ^ir[13:0];
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller driving every dataPath control pin.
//   clk, rst (async, active-high), instruction (sampled in FETCH), COutput/ZOutput (datapath flags)
//   outputs: pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemRead, DMMemWrite, pc3inputMuxSelectAddress,
//            regFileReadRegister2Select, ALUBInputSelect, ALUOperation, regFileWriteDataSelect,
//            SHROOperation, illegal (one-cycle pulse when an instruction runs as a NOP)
//   CTRL_RETURN_STACK_EN: when defined, JSB/RET use a return-stack depth counter of STACK_DEPTH
//   entries; when undefined, JSB/RET are illegal NOPs and push/pop/RET stay 0.
module control_unit
    import ctrl_pkg::*;
#(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] instruction,
    input  logic        COutput,
    input  logic        ZOutput,
    output logic        pcEn,
    output logic        CEn,
    output logic        ZEn,
    output logic        push,
    output logic        pop,
    output logic        RET,
    output logic        regWrite,
    output logic        DMMemRead,
    output logic        DMMemWrite,
    output logic [1:0]  pc3inputMuxSelectAddress,
    output logic        regFileReadRegister2Select,
    output logic        ALUBInputSelect,
    output logic [2:0]  ALUOperation,
    output logic [1:0]  regFileWriteDataSelect,
    output logic [1:0]  SHROOperation,
    output logic        illegal
);
    if (STACK_DEPTH < 1 || STACK_DEPTH > 255) begin : g_depth_check
        $error("STACK_DEPTH must be in 1..255");
    end

    state_t      state, next_state;
    logic [18:0] ir;
    logic        is_alu, is_imm, is_ldm, is_stm, is_shift, is_branch, is_jmp, is_jsb, is_ret, is_bad;
    logic [2:0]  alu_op;
    logic [1:0]  sub_op;
    logic        exec, mem, wb, in_body, jsb_ok, ret_ok, nop;

    ctrl_decoder u_dec (
        .ir        (ir),
        .is_alu    (is_alu),
        .is_imm    (is_imm),
        .is_ldm    (is_ldm),
        .is_stm    (is_stm),
        .is_shift  (is_shift),
        .is_branch (is_branch),
        .is_jmp    (is_jmp),
        .is_jsb    (is_jsb),
        .is_ret    (is_ret),
        .is_bad    (is_bad),
        .alu_op    (alu_op),
        .sub_op    (sub_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH) ir <= instruction;
        end
    end

    always_comb begin
        next_state = state == S_FETCH  ? S_DECODE :
                     state == S_DECODE ? S_EXEC :
                     state == S_EXEC   ? (is_alu || is_shift ? S_WB : is_ldm || is_stm ? S_MEM : S_FETCH) :
                     state == S_MEM    ? (is_ldm ? S_WB : S_FETCH) : S_FETCH;
    end

    assign exec    = state == S_EXEC;
    assign mem     = state == S_MEM;
    assign wb      = state == S_WB;
    assign in_body = exec || mem || wb;
    // Overflowing JSB, underflowing RET and the reserved jump op all fall through as PC+1.
    assign nop     = is_bad || (is_jsb && !jsb_ok) || (is_ret && !ret_ok);

`ifdef CTRL_RETURN_STACK_EN
    localparam logic [7:0] DEPTH_MAX = 8'(STACK_DEPTH);
    logic [7:0] depth;

    assign jsb_ok = is_jsb && depth != DEPTH_MAX;
    assign ret_ok = is_ret && depth != 8'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) depth <= '0;
        else if (exec && jsb_ok) depth <= depth + 8'd1;
        else if (exec && ret_ok) depth <= depth - 8'd1;
    end
`else
    assign jsb_ok = 1'b0;
    assign ret_ok = 1'b0;
`endif

    // Datapath selects are held from EXEC to the end of the instruction so MEM/WB see stable operands.
    always_comb begin
        ALUOperation               = in_body && is_alu ? alu_op : ALU_ADD;
        ALUBInputSelect            = in_body && (is_imm || is_ldm || is_stm);
        SHROOperation              = in_body && is_shift ? sub_op : 2'b00;
        regFileReadRegister2Select = in_body && (is_alu || is_shift);
        regFileWriteDataSelect     = !in_body ? WD_SRC_ALU : is_shift ? WD_SRC_SHR : is_ldm ? WD_SRC_MEM : WD_SRC_ALU;
        ZEn                        = exec && (is_alu || is_shift);
        CEn                        = exec && ((is_alu && alu_op <= ALU_SUBC) || is_shift);
        push                       = exec && jsb_ok;
        pop                        = exec && ret_ok;
        RET                        = exec && ret_ok;
        illegal                    = exec && nop;
        DMMemRead                  = mem && is_ldm;
        DMMemWrite                 = mem && is_stm;
        regWrite                   = wb;
        pcEn                       = wb || (mem && is_stm) ||
                                     (exec && (is_branch || is_jmp || is_jsb || is_ret || is_bad));
        pc3inputMuxSelectAddress   = !exec ? PC_SRC_INC :
                                     is_branch && br_taken(sub_op, ZOutput, COutput) ? PC_SRC_BR :
                                     is_jmp || jsb_ok ? PC_SRC_JMP :
                                     ret_ok ? PC_SRC_STK : PC_SRC_INC;
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus random instruction stream checked cycle by cycle against a behavioural model.
module tb_control_unit;
    localparam int SD = 8;
`ifdef CTRL_RETURN_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    typedef struct packed {
        logic       pcen, cen, zen, push, pop, ret, rw, rd, wr;
        logic [1:0] pcsel;
        logic       rs2, bsel;
        logic [2:0] aluop;
        logic [1:0] wdsel, shrop;
        logic       ill;
    } ov_t;

    logic        clk, rst, z_flag, c_flag;
    logic [18:0] instruction;
    logic        pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemRead, DMMemWrite;
    logic [1:0]  pcsel, wdsel, shrop;
    logic        rs2sel, bsel, illegal;
    logic [2:0]  aluop;
    ov_t         obs;
    int          n_cmp = 0, n_fail = 0, mdepth = 0;

    control_unit #(.STACK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .COutput(c_flag), .ZOutput(z_flag),
        .pcEn(pcEn), .CEn(CEn), .ZEn(ZEn), .push(push), .pop(pop), .RET(RET), .regWrite(regWrite),
        .DMMemRead(DMMemRead), .DMMemWrite(DMMemWrite), .pc3inputMuxSelectAddress(pcsel),
        .regFileReadRegister2Select(rs2sel), .ALUBInputSelect(bsel), .ALUOperation(aluop),
        .regFileWriteDataSelect(wdsel), .SHROOperation(shrop), .illegal(illegal)
    );

    assign obs = {pcEn, CEn, ZEn, push, pop, RET, regWrite, DMMemRead, DMMemWrite,
                  pcsel, rs2sel, bsel, aluop, wdsel, shrop, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cycles(input logic [18:0] ins);
        if (!ins[18] || ins[18:16] == 3'b101) return 4;
        if (ins[18:15] == 4'b1000) return 5;
        if (ins[18:15] == 4'b1001) return 4;
        return 3;
    endfunction

    // Expected control outputs in cycle k (FETCH = 1) of instruction ins with live flags z/c.
    function automatic ov_t model(input logic [18:0] ins, input int k, input logic z, input logic c);
        ov_t o;
        logic alu, shf, mem, ldm, br, jg, taken;
        logic [3:0] conds;
        o     = '0;
        alu   = !ins[18];
        shf   = ins[18:16] == 3'b101;
        mem   = ins[18:16] == 3'b100;
        ldm   = mem && !ins[15];
        br    = ins[18:16] == 3'b110;
        jg    = ins[18:16] == 3'b111;
        conds = {!c, c, !z, z};
        taken = conds[ins[15:14]];
        if (k < 3) return o;
        o.aluop = alu ? ins[16:14] : 3'd0;
        o.bsel  = ins[18:17] == 2'b01 || mem;
        o.shrop = shf ? ins[15:14] : 2'd0;
        o.rs2   = alu || shf;
        o.wdsel = shf ? 2'd2 : ldm ? 2'd1 : 2'd0;
        if (k == 3) begin
            o.zen = alu || shf;
            o.cen = shf || (alu && ins[16:14] < 3'd4);
            if (br) begin
                o.pcen  = 1'b1;
                o.pcsel = taken ? 2'd1 : 2'd0;
            end
            if (jg) begin
                o.pcen = 1'b1;
                if (ins[15:14] == 2'd0) o.pcsel = 2'd2;
                else if (ins[15:14] == 2'd1 && STK && mdepth < SD) begin
                    o.pcsel = 2'd2;
                    o.push  = 1'b1;
                end else if (ins[15:14] == 2'd2 && STK && mdepth > 0) begin
                    o.pcsel = 2'd3;
                    o.pop   = 1'b1;
                    o.ret   = 1'b1;
                end else o.ill = 1'b1;
            end
        end
        if (k == 4 && mem) begin
            o.rd   = ldm;
            o.wr   = !ldm;
            o.pcen = !ldm;
        end
        if (k == cycles(ins) && (alu || shf || ldm)) begin
            o.rw   = 1'b1;
            o.pcen = 1'b1;
        end
        return o;
    endfunction

    task automatic check(input ov_t exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // zf/cf: 0 or 1 forces the flag, 2 randomizes it every cycle. abort_at > 0 pulses rst in that cycle.
    task automatic run_instr(input logic [18:0] ins, input int zf, input int cf, input int abort_at, input string tag);
        int n;
        n = cycles(ins);
        instruction = ins;
        for (int k = 1; k <= n; k++) begin
            z_flag = zf > 1 ? 1'($urandom) : 1'(zf);
            c_flag = cf > 1 ? 1'($urandom) : 1'(cf);
            if (k == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                check('0, $sformatf("%s.abort", tag));
                @(posedge clk);
                #1;
                rst    = 1'b0;
                mdepth = 0;
                return;
            end
            @(negedge clk);
            check(model(ins, k, z_flag, c_flag), $sformatf("%s.c%0d", tag, k));
            if (k == 3 && STK && ins[18:16] == 3'b111) begin
                if (ins[15:14] == 2'd1 && mdepth < SD) mdepth++;
                else if (ins[15:14] == 2'd2 && mdepth > 0) mdepth--;
            end
            @(posedge clk);
            #1;
            if (k == 1) instruction = 19'($urandom);
        end
    endtask

    localparam logic [18:0] I_ADD  = 19'b00_000_001_010_011_00000;
    localparam logic [18:0] I_LDM  = 19'b10_0_0_0_001_010_00000101;
    localparam logic [18:0] I_STM  = 19'b10_0_1_0_011_100_00001001;
    localparam logic [18:0] I_SHR  = 19'b10_1_10_010_011_011_00000;
    localparam logic [18:0] I_ANDI = 19'b01_100_001_001_11110000;
    localparam logic [18:0] I_SUB  = 19'b00_010_101_110_111_00000;
    localparam logic [18:0] I_BZ   = 19'b110_00_000000_00010000;
    localparam logic [18:0] I_BNC  = 19'b110_11_000000_11111000;
    localparam logic [18:0] I_JMP  = 19'b111_00_000000_00100000;
    localparam logic [18:0] I_JSB  = 19'b111_01_000000_01000000;
    localparam logic [18:0] I_RET  = 19'b111_10_000000_00000000;
    localparam logic [18:0] I_BAD  = 19'b111_11_000000_00000000;

    initial begin
        rst = 1'b1;
        instruction = '0;
        z_flag = 1'b0;
        c_flag = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check('0, "reset");
        rst = 1'b0;
        run_instr(I_ADD, 2, 2, 0, "add");
        run_instr(I_LDM, 2, 2, 0, "ldm");
        run_instr(I_BZ, 1, 2, 0, "bz_taken");
        run_instr(I_BZ, 0, 2, 0, "bz_not");
        run_instr(I_BNC, 2, 0, 0, "bnc_taken");
        run_instr(I_BNC, 2, 1, 0, "bnc_not");
        run_instr(I_JSB, 2, 2, 0, "jsb");
        run_instr(I_RET, 2, 2, 0, "ret");
        run_instr(I_RET, 2, 2, 0, "ret_empty");
        for (int i = 0; i < SD + 1; i++) run_instr(I_JSB, 2, 2, 0, $sformatf("jsb%0d", i));
        for (int i = 0; i < SD + 1; i++) run_instr(I_RET, 2, 2, 0, $sformatf("ret%0d", i));
        run_instr(I_BAD, 2, 2, 0, "bad");
        run_instr(I_JMP, 2, 2, 0, "jmp");
        run_instr(I_STM, 2, 2, 0, "stm");
        run_instr(I_SHR, 2, 2, 0, "shr");
        run_instr(I_ANDI, 2, 2, 0, "andi");
        run_instr(I_SUB, 2, 2, 0, "sub");
        run_instr(I_JSB, 2, 2, 0, "jsb_pre_rst");
        run_instr(I_LDM, 2, 2, 4, "ldm_rst");
        run_instr(I_ADD, 2, 2, 0, "add_post_rst");
        run_instr(I_RET, 2, 2, 0, "ret_post_rst");
        for (int i = 0; i < 150; i++) run_instr(19'($urandom), 2, 2, 0, $sformatf("rnd%0d", i));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle controller for the 19-bit processor. It consumes the fetched `instruction` and the `COutput`/`ZOutput` flags from `dataPath`, and produces every control input of `dataPath`. It sits directly upstream of `dataPath`'s control pins. The instruction is latched into an internal IR, sequenced through FETCH/DECODE/EXEC/MEM/WB, and `pcEn` is issued exactly once per instruction.

## Interface
- `STACK_DEPTH`, default 8: return-stack entries tracked by the depth counter; range 1..255.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `instruction` in 19: instruction-memory output, sampled in FETCH.
- `COutput`, `ZOutput` in 1 each: datapath carry and zero flags.
- `pcEn`, `CEn`, `ZEn`, `push`, `pop`, `RET`, `regWrite`, `DMMemRead`, `DMMemWrite` out 1 each: datapath enables.
- `pc3inputMuxSelectAddress` out 2: PC source. 00 = PC+1, 01 = branch target, 10 = jump target, 11 = stack top.
- `regFileReadRegister2Select` out 1: 1 = Rt field, 0 = Rd field (store data).
- `ALUBInputSelect` out 1: 0 = register, 1 = imm8.
- `ALUOperation` out 3: ALU opcode.
- `regFileWriteDataSelect` out 2: 00 = ALU, 01 = data memory, 10 = shifter.
- `SHROOperation` out 2: shift/rotate opcode.
- `illegal` out 1: one-cycle pulse marking an instruction executed as a NOP.

## Operation
- Encoding uses IR[18:17] as the class field.
  - 00 = R-type ALU: [16:14] op, [13:11] Rd, [10:8] Rs, [7:5] Rt.
  - 01 = I-type ALU: [16:14] op, Rd, Rs, [7:0] imm8.
  - 10 with [16]=0 = memory: [15] 0 = LDM, 1 = STM; [13:11] Rd, [10:8] base, imm8.
  - 10 with [16]=1 = shift: [15:14] SHROOperation, Rd, Rs, [7:5] amount.
  - 110 = branch: [15:14] 00 BZ, 01 BNZ, 10 BC, 11 BNC; imm8 offset.
  - 111 = jump group: [15:14] 00 JMP, 01 JSB, 10 RET, 11 illegal.
- ALU ops: 000 ADD, 001 ADDC, 010 SUB, 011 SUBC, 100 AND, 101 OR, 110 XOR, 111 MASK.
- FSM transitions:
  - FETCH → DECODE: IR ← `instruction`.
  - DECODE → EXEC.
  - EXEC → WB for ALU and shift.
  - EXEC → MEM for LDM and STM.
  - EXEC → FETCH for branch and jump-group instructions.
  - MEM → WB for LDM; MEM → FETCH for STM.
  - WB → FETCH.
- Outputs are decoded combinationally from state and IR; all outputs are 0 in FETCH and DECODE.
- EXEC (ALU/shift):
  - Drives `ALUOperation`, `ALUBInputSelect`, `SHROOperation` and `regFileReadRegister2Select`.
  - `ZEn`=1 for all ALU and shift ops.
  - `CEn`=1 only for ops 000–011 and for shifts.
- Datapath selects are held stable from EXEC through the last state of the instruction.
- WB: `regWrite`=1 and `pcEn`=1 with select 00; `regFileWriteDataSelect` is 00 for ALU, 10 for shift, 01 for LDM.
- Memory ops:
  - LDM: `ALUBInputSelect`=1 and ADD in EXEC, then `DMMemRead`=1 in MEM.
  - STM: same EXEC, then `DMMemWrite`=1, `regFileReadRegister2Select`=0 and `pcEn`=1 in MEM.
- Branch in EXEC: taken is evaluated from live `ZOutput`/`COutput`. `pcEn`=1, select 01 if taken, 00 if not.
- Jump group in EXEC, each with `pcEn`=1:
  - JMP: select 10.
  - JSB: select 10, `push`=1, depth+1.
  - RET: select 11, `pop`=1, `RET`=1, depth−1.
- Boundary conditions: JSB with depth==STACK_DEPTH, RET with depth==0, and opcode 111/11 all execute as NOP (`pcEn`=1, select 00, no push/pop). `illegal`=1 in that EXEC cycle.

## Timing
- Reset: state FETCH, IR=0, depth=0; every output 0.
- `rst` asserted mid-instruction aborts it. No `pcEn`, `regWrite` or `DMMemWrite` is issued, and the FSM resumes in FETCH after deassertion.
- Latency in cycles, counted from the FETCH cycle as cycle 1:
  - ALU/shift: 4, with flags enabled in cycle 3 and `regWrite`/`pcEn` in cycle 4.
  - LDM: 5.
  - STM: 4.
  - Branch and jump group: 3.
- Flags are written only in EXEC of an ALU or shift instruction, so a branch always sees the flags of the last such instruction.

## Configuration
- `CTRL_RETURN_STACK_EN`
  - Defined: JSB and RET behave as above, including the depth counter and overflow/underflow NOPs.
  - Undefined: no depth counter; JSB and RET decode as illegal NOPs; `push`, `pop` and `RET` are tied to 0.

## Structure
- `ctrl_pkg` holds the state enum, the class/opcode/branch-condition constants, the ALU op codes and the mux-select constants (PC_SRC_*, WD_SRC_*).
- Sub-module `ctrl_decoder` (combinational) maps IR to instruction class, condition and field strobes.
- `control_unit` owns the FSM, IR, depth counter and output drive.

## Test plan
- Reset, then R-type ADD (00_000_001_010_011_00000) → `CEn`=`ZEn`=1 and `ALUOperation`=000 in cycle 3; `regWrite`=1, `pcEn`=1, select 00 in cycle 4.
- LDM (10_0_0_x_001_010_imm8=0x05) → `ALUBInputSelect`=1 in cycle 3, `DMMemRead`=1 in cycle 4, `regWrite`=1 with write-data select 01 in cycle 5.
- BZ with `ZOutput`=1 → `pcEn`=1, select 01 in cycle 3; repeat with `ZOutput`=0 → select 00.
- JSB then RET → `push`=1 with select 10, then `pop`=`RET`=1 with select 11; depth returns to 0.
- Nine consecutive JSBs with STACK_DEPTH=8 → ninth produces `illegal`=1, `push`=0, select 00; a RET at depth 0 likewise.
- `rst` pulsed during MEM of an LDM → no `regWrite`; the next cycle after release is FETCH with all outputs 0.
